// File: rtl/vid_axis_pkg.sv
// Shared types and sizing helpers for the video-to-AXI4-Stream bridge.
package vid_axis_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    RUN        = 2'd2,
    DROP       = 2'd3
  } state_t;

  // FIFO entry layout for the default 8-bit-per-component pixel; the bridge
  // builds the same {tuser, tlast, tdata} layout at its configured width.
  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [23:0] tdata;
  } fifo_entry_t;

  // Bits needed to hold any value in 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vid_axis_fifo.sv
// Synchronous first-word-fall-through FIFO. Reads return zero while empty so
// the stream outputs are clean after reset.
module vid_axis_fifo
  import vid_axis_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int DEPTH = 2048
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO succeeds when the head is leaving this cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vid2axis_bridge.sv
// Sync-based parallel video to AXI4-Stream bridge (VDMA S2MM side).
//
//   state      | meaning
//   IDLE       | capture disabled, waiting for frame start with enable
//   WAIT_FIRST | frame started, waiting for first active pixel (gets tuser)
//   RUN        | every active pixel is staged and written to the FIFO
//   DROP       | FIFO overflowed, rest of frame discarded until next start
module vid2axis_bridge
  import vid_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int FIFO_DEPTH = 2048,
  parameter int VSYNC_POL  = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_vde,
  input  logic                    in_hsync,
  input  logic                    in_vsync,
  input  logic [3*DATA_WIDTH-1:0] in_data,
  input  logic                    enable,
  input  logic                    clr_status,
  output logic [3*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    overflow,
  output logic                    line_err,
  output logic [15:0]             frame_cnt
);

  localparam int PIX_W = 3 * DATA_WIDTH;
  localparam int EW    = PIX_W + 2;
  localparam int PX_W  = (cnt_w(H_ACTIVE) < 11) ? 11 : cnt_w(H_ACTIVE);
  localparam int LN_W  = (cnt_w(V_ACTIVE) < 11) ? 11 : cnt_w(V_ACTIVE);
  localparam int FC_W  = cnt_w(FIFO_DEPTH);

  typedef struct packed {
    logic             tuser;
    logic             tlast;
    logic [PIX_W-1:0] tdata;
  } entry_t;

  state_t           state, state_nxt;
  logic             vs_act, vs_q, vs_q2, fs;
  logic             stg_valid, stg_sof, sof_pend;
  logic [PIX_W-1:0] stg_data;
  logic [PX_W-1:0]  px_cnt;
  logic [LN_W-1:0]  line_cnt, lines_done;
  logic             capture, rd_en, wr_ok, ovf_evt, tlast_wr, len_err, frm_err, run_fs;
  entry_t           wr_entry, rd_entry;
  logic             fifo_full, fifo_empty;
  logic [FC_W-1:0]  fifo_count_unused;
  logic             hsync_unused;

  // Line ends come from VDE, so hsync carries nothing the bridge needs.
  assign hsync_unused = in_hsync;

  assign vs_act   = (in_vsync == (VSYNC_POL != 0));
  assign fs       = vs_q && !vs_q2;
  assign run_fs   = fs && (state == RUN);
  assign rd_en    = m_axis_tready && !fifo_empty;
  assign wr_ok    = stg_valid && (!fifo_full || rd_en);
  assign ovf_evt  = stg_valid && fifo_full && !rd_en;
  assign capture  = in_vde && !fs && !ovf_evt && (state == RUN || state == WAIT_FIRST);
  assign tlast_wr = wr_ok && wr_entry.tlast;

  assign wr_entry.tuser = stg_sof;
  assign wr_entry.tlast = !in_vde;
  assign wr_entry.tdata = stg_data;

  assign lines_done = line_cnt + LN_W'(tlast_wr);
  assign len_err    = tlast_wr && ((px_cnt + PX_W'(1)) != PX_W'(H_ACTIVE));
  assign frm_err    = run_fs && !ovf_evt && (lines_done != LN_W'(V_ACTIVE));

  vid_axis_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (stg_valid),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = rd_entry.tdata;
  assign m_axis_tuser  = rd_entry.tuser;
  assign m_axis_tlast  = rd_entry.tlast;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; an overflow always forces DROP.
  always_comb begin
    state_nxt = state;
    if (ovf_evt) begin
      state_nxt = DROP;
    end else begin
      case (state)
        IDLE:       if (fs && enable) state_nxt = WAIT_FIRST;
        WAIT_FIRST: if (fs)           state_nxt = enable ? WAIT_FIRST : IDLE;
                    else if (in_vde)  state_nxt = RUN;
        RUN:        if (fs && !enable) state_nxt = IDLE;
        DROP:       if (fs && enable) state_nxt = WAIT_FIRST;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // Vsync edge detect and one-pixel staging; the staged pixel's tlast is only
  // known once the following cycle's VDE is seen.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vs_q      <= 1'b0;
      vs_q2     <= 1'b0;
      stg_valid <= 1'b0;
      stg_sof   <= 1'b0;
      stg_data  <= '0;
      sof_pend  <= 1'b0;
    end else begin
      vs_q      <= vs_act;
      vs_q2     <= vs_q;
      stg_valid <= capture;
      if (capture) begin
        stg_data <= in_data;
        stg_sof  <= (state == WAIT_FIRST) || sof_pend;
      end
      if (run_fs && enable && !ovf_evt) sof_pend <= 1'b1;
      else if (capture)                 sof_pend <= 1'b0;
    end
  end

  // Pixel/line counters; a tlast written on the frame-start cycle still
  // belongs to the old frame via lines_done.
  always_ff @(posedge clk) begin
    if (!rstn || fs) begin
      px_cnt   <= '0;
      line_cnt <= '0;
    end else if (wr_ok) begin
      if (wr_entry.tlast) begin
        px_cnt   <= '0;
        line_cnt <= line_cnt + LN_W'(1);
      end else begin
        px_cnt   <= px_cnt + PX_W'(1);
      end
    end
  end

  // Sticky status flags (set beats clear) and completed-frame counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      line_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (ovf_evt)         overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;
      if (len_err || frm_err) line_err <= 1'b1;
      else if (clr_status)    line_err <= 1'b0;
      if (run_fs && !ovf_evt) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vid2axis_bridge.sv
// Scoreboard bench for vid2axis_bridge with small 8x4 frames.
module tb_vid2axis_bridge;

  localparam int H = 8;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_vde = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0;
  logic [23:0] in_data = '0;
  logic        enable = 1'b0, clr_status = 1'b0, m_axis_tready = 1'b1;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, overflow, line_err;
  logic [15:0] frame_cnt;

  logic [25:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  vid2axis_bridge #(
    .DATA_WIDTH (8),
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FIFO_DEPTH (16),
    .VSYNC_POL  (1)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_vde        (in_vde),
    .in_hsync      (in_hsync),
    .in_vsync      (in_vsync),
    .in_data       (in_data),
    .enable        (enable),
    .clr_status    (clr_status),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .line_err      (line_err),
    .frame_cnt     (frame_cnt)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: a beat transfers at the next rising edge when valid and ready.
  always @(negedge clk) begin
    logic [25:0] e;
    if (rstn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got {tuser,tlast,tdata}=%0h, expected no beat (t=%0t)",
                 {m_axis_tuser, m_axis_tlast, m_axis_tdata}, $time);
      end else begin
        e = exp_q.pop_front();
        check("beat", {6'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {6'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_cnt > 0) begin
      stall_cnt--;
      if (stall_cnt == 0) m_axis_tready = 1'b1;
    end
  endtask

  task automatic vsync_pulse();
    in_vsync = 1'b1;
    tick(); tick();
    in_vsync = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  // keep: number of leading pixels expected on the stream; -1 args disable.
  task automatic frame_data(input int keep, input int short_line, input bit clr_short,
                            input int en_off_line, input int stall_at, input int rst_at,
                            input bit chk_lat);
    int idx;
    int len;
    logic [25:0] ent;
    idx = 0;
    for (int ln = 0; ln < V; ln++) begin
      len = (ln == short_line) ? H - 1 : H;
      if (ln == en_off_line) enable = 1'b0;
      for (int px = 0; px < len; px++) begin
        in_vde  = 1'b1;
        in_data = 24'(ln * 8 + px);
        if (idx < keep) begin
          ent = {(ln == 0 && px == 0), (px == len - 1), 24'(ln * 8 + px)};
          exp_q.push_back(ent);
        end
        if (idx == stall_at) begin
          m_axis_tready = 1'b0;
          stall_cnt = 28;
        end
        if (chk_lat && idx == 1) check("latency_n1_tvalid", m_axis_tvalid, 0);
        if (chk_lat && idx == 2) check("latency_n2_tvalid", m_axis_tvalid, 1);
        if (idx == rst_at) begin
          rstn = 1'b0;
          tick();
          rstn = 1'b1;
          exp_q.delete();
          check("midreset_tvalid", m_axis_tvalid, 0);
          check("midreset_frame_cnt", frame_cnt, 0);
          check("midreset_overflow", overflow, 0);
        end else begin
          tick();
        end
        idx++;
      end
      in_vde = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (clr_short && ln == short_line && b == 0) clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check("reset_tvalid", m_axis_tvalid, 0);
    check("reset_tdata", m_axis_tdata, 0);
    check("reset_tuser", m_axis_tuser, 0);
    check("reset_tlast", m_axis_tlast, 0);
    check("reset_overflow", overflow, 0);
    check("reset_line_err", line_err, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    rstn = 1'b1;
    enable = 1'b1;
    tick();

    // Three clean frames, latency checked on the very first pixel.
    vsync_pulse(); frame_data(32, -1, 0, -1, -1, -1, 1);
    vsync_pulse(); check("fc_after_fs2", frame_cnt, 1);
    frame_data(32, -1, 0, -1, -1, -1, 0);
    vsync_pulse(); check("fc_after_fs3", frame_cnt, 2);
    frame_data(32, -1, 0, -1, -1, -1, 0);
    check("clean_line_err", line_err, 0);
    check("clean_overflow", overflow, 0);

    // Backpressure from line 1: lines 1-2 fill the FIFO, line 3 overflows.
    vsync_pulse(); check("fc_after_fs4", frame_cnt, 3);
    frame_data(24, -1, 0, -1, 8, -1, 0);
    check("ovf_set", overflow, 1);
    check("ovf_no_line_err", line_err, 0);
    vsync_pulse(); check("fc_dropped_frame", frame_cnt, 3);
    frame_data(32, -1, 0, -1, -1, -1, 0);
    pulse_clr();
    check("ovf_cleared", overflow, 0);

    // Short line sets line_err; clear; then set and clear together.
    vsync_pulse(); check("fc_after_fs6", frame_cnt, 4);
    frame_data(31, 1, 0, -1, -1, -1, 0);
    check("short_line_err", line_err, 1);
    pulse_clr();
    check("line_err_cleared", line_err, 0);
    vsync_pulse(); check("fc_after_fs7", frame_cnt, 5);
    frame_data(31, 2, 1, -1, -1, -1, 0);
    check("set_beats_clr", line_err, 1);
    pulse_clr();
    check("line_err_cleared2", line_err, 0);

    // Enable dropped mid-frame: frame completes, next frame skipped.
    vsync_pulse(); check("fc_after_fs8", frame_cnt, 6);
    frame_data(32, -1, 0, 2, -1, -1, 0);
    vsync_pulse(); check("fc_enable_off", frame_cnt, 7);
    frame_data(0, -1, 0, -1, -1, -1, 0);
    enable = 1'b1;
    vsync_pulse(); check("fc_idle_fs", frame_cnt, 7);
    frame_data(32, -1, 0, -1, -1, -1, 0);

    // Reset mid-line, then recovery on the following full frame.
    vsync_pulse(); check("fc_after_resume", frame_cnt, 8);
    frame_data(11, -1, 0, -1, -1, 11, 0);
    vsync_pulse(); check("fc_after_reset_fs", frame_cnt, 0);
    frame_data(32, -1, 0, -1, -1, -1, 0);
    vsync_pulse(); check("fc_final", frame_cnt, 1);

    drain();
    check("final_line_err", line_err, 0);
    check("final_overflow", overflow, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
